// File: rtl/we_pkg.sv
// Shared types and constants for the active-low write-enable register and its read port.
// Pure declarations; no logic, no latency, no backpressure.
package we_pkg;

  localparam int W_DEFAULT  = 64;
  localparam int CW_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // All-ones value that a saturating counter of the default width stops at
  localparam logic [CW_DEFAULT-1:0] OVR_MAX = '1;

endpackage

// File: rtl/rd_port_if.sv
// Read-port bundle: writer commit, read request, output valid/ready and status.
// The master drives the requests and out_ready; the slave (rd_port) drives data and status.
interface rd_port_if
  import we_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
);

  logic          wr_pulse;
  logic [W-1:0]  wr_data;
  logic          rn;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          out_ready;
  logic          fresh;
  logic [CW-1:0] ovr_cnt;

  modport master (
    output wr_pulse, wr_data, rn, out_ready,
    input  out, out_valid, fresh, ovr_cnt
  );

  modport slave (
    input  wr_pulse, wr_data, rn, out_ready,
    output out, out_valid, fresh, ovr_cnt
  );

endinterface

// File: rtl/rd_port_formal.sv
// Passive property checker for rd_port outputs, attached alongside the port.
// past_valid masks the first cycle after reset, where there is no previous sample to compare.
module rd_port_formal
  import we_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  input logic [W-1:0]  out,
  input logic          out_valid,
  input logic          out_ready,
  input logic [CW-1:0] ovr_cnt
);

  logic          past_valid;
  logic [W-1:0]  out_p;
  logic          valid_p;
  logic          ready_p;
  logic [CW-1:0] ovr_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      past_valid <= 1'b0;
      out_p      <= '0;
      valid_p    <= 1'b0;
      ready_p    <= 1'b0;
      ovr_p      <= '0;
    end else begin
      past_valid <= 1'b1;
      out_p      <= out;
      valid_p    <= out_valid;
      ready_p    <= out_ready;
      ovr_p      <= ovr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && past_valid) begin
      a_out_stable: assert (!(valid_p && !ready_p) || (out_valid && out == out_p));
      a_valid_fall: assert (!(valid_p && !out_valid) || ready_p);
      a_ovr_mono:   assert (ovr_cnt >= ovr_p);
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Count visible one cycle after inc; inc is never refused.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rd_port.sv
// Shadows the writer's committed word and serves active-low read requests, 1-cycle latency.
// A held word freezes until out_ready; requests made while it is held and not accepted are dropped.
module rd_port
  import we_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  rd_port_if.slave   bus
);

  state_t         state;
  state_t         state_nxt;
  logic           capture;
  logic [W-1:0]   shadow;
  logic [W-1:0]   cap_val;
  logic [W-1:0]   out_q;
  logic           out_valid_q;
  logic           fresh_q;
  logic           ovr_inc;
  logic [CW-1:0]  ovr_q;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.rn) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!bus.rn) begin
            capture = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bypass so a read in the same cycle as a commit returns the new word
  assign cap_val = bus.wr_pulse ? bus.wr_data : shadow;
  assign ovr_inc = bus.wr_pulse && fresh_q && !capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fresh_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == HOLD);
      if (bus.wr_pulse) begin
        shadow <= bus.wr_data;
      end
      if (capture) begin
        out_q   <= cap_val;
        fresh_q <= 1'b0;
      end else if (bus.wr_pulse) begin
        fresh_q <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CW)) u_ovr (
    .clk (clk),
    .rst (rst),
    .inc (ovr_inc),
    .cnt (ovr_q)
  );

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fresh     = fresh_q;
  assign bus.ovr_cnt   = ovr_q;

endmodule

// File: tb/tb_rd_port.sv
// Scoreboarded bench for rd_port: reads push expected words, output handshakes pop them.
module tb_rd_port;
  import we_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rd_port_if #(.W(64), .CW(8)) b ();
  rd_port_if #(.W(64), .CW(2)) b2 ();

  rd_port #(.W(64), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  rd_port #(.W(64), .CW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  rd_port_formal #(.W(64), .CW(8)) fv (
    .clk       (clk),
    .rst       (rst),
    .out       (b.out),
    .out_valid (b.out_valid),
    .out_ready (b.out_ready),
    .ovr_cnt   (b.ovr_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] sb[$];
  logic [63:0] sh_m;
  logic [63:0] out_m;
  logic        hold_m;
  logic        fresh_m;
  logic [7:0]  ovr_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sh_m    = '0;
    out_m   = '0;
    hold_m  = 1'b0;
    fresh_m = 1'b0;
    ovr_m   = '0;
    sb.delete();
  endtask

  // One clock of stimulus on the main port, with the model stepped alongside
  task automatic cyc(input logic wp, input logic [63:0] wd, input logic r, input logic rdy);
    logic        cap;
    logic [63:0] cv;
    b.wr_pulse  = wp;
    b.wr_data   = wd;
    b.rn        = r;
    b.out_ready = rdy;
    cap = !r && (!hold_m || rdy);
    cv  = wp ? wd : sh_m;
    if (wp && fresh_m && !cap && ovr_m != 8'hFF) ovr_m = ovr_m + 8'd1;
    if (cap) begin
      fresh_m = 1'b0;
      out_m   = cv;
      sb.push_back(cv);
    end else if (wp) begin
      fresh_m = 1'b1;
    end
    if (wp) sh_m = wd;
    if (cap) hold_m = 1'b1;
    else if (hold_m && rdy) hold_m = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(b.out_valid), 64'(hold_m));
    chk("out", b.out, out_m);
    chk("fresh", 64'(b.fresh), 64'(fresh_m));
    chk("ovr_cnt", 64'(b.ovr_cnt), 64'(ovr_m));
  endtask

  // A transfer completes at the edge following a low-phase sample of valid && ready
  always @(negedge clk) begin
    if (!rst && b.out_valid && b.out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("sb_out", b.out, sb.pop_front());
    end
  end

  initial begin
    b.wr_pulse = 1'b0; b.wr_data = '0; b.rn = 1'b1; b.out_ready = 1'b1;
    b2.wr_pulse = 1'b0; b2.wr_data = '0; b2.rn = 1'b1; b2.out_ready = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", b.out, 64'd0);
    chk("rst_valid", 64'(b.out_valid), 64'd0);
    chk("rst_fresh", 64'(b.fresh), 64'd0);
    chk("rst_ovr", 64'(b.ovr_cnt), 64'd0);

    // Write, wait, then read with latency 1
    cyc(1'b1, 64'h123456A, 1'b1, 1'b1);
    chk("t2_fresh_c1", 64'(b.fresh), 64'd1);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);
    chk("t2_fresh_c2", 64'(b.fresh), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    chk("t2_out", b.out, 64'h123456A);
    chk("t2_valid", 64'(b.out_valid), 64'd1);
    chk("t2_fresh_c3", 64'(b.fresh), 64'd0);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);

    // Same-cycle write and read takes the bypass
    cyc(1'b1, 64'hDEADBEEF, 1'b0, 1'b1);
    chk("t3_out", b.out, 64'hDEADBEEF);
    chk("t3_fresh", 64'(b.fresh), 64'd0);
    chk("t3_ovr", 64'(b.ovr_cnt), 64'd0);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);

    // Stall holds the word; a write during stall only updates the shadow
    cyc(1'b1, 64'hA, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0);
    chk("t4_out_held", b.out, 64'hA);
    chk("t4_valid_held", 64'(b.out_valid), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    chk("t4_out_b2b", b.out, 64'hB);
    chk("t4_valid_b2b", 64'(b.out_valid), 64'd1);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);

    // Unread overwrites count as overruns; the wide counter and the 2-bit one
    cyc(1'b1, 64'd1, 1'b1, 1'b1);
    cyc(1'b1, 64'd2, 1'b1, 1'b1);
    cyc(1'b1, 64'd3, 1'b1, 1'b1);
    chk("t5_ovr", 64'(b.ovr_cnt), 64'd2);
    chk("t5_fresh", 64'(b.fresh), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    chk("t5_read", b.out, 64'd3);
    b2.wr_pulse = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b2.wr_data = 64'(i + 1);
      cyc(1'b0, 64'd0, 1'b1, 1'b1);
      if (i == 2) chk("t5_cw2_mid", 64'(b2.ovr_cnt), 64'd2);
    end
    b2.wr_pulse = 1'b0;
    cyc(1'b0, 64'd0, 1'b1, 1'b1);
    chk("t5_cw2_sat", 64'(b2.ovr_cnt), 64'd3);
    chk("t5_cw2_fresh", 64'(b2.fresh), 64'd1);

    // Async reset while holding a stalled word
    cyc(1'b1, 64'h55, 1'b0, 1'b0);
    chk("t6_hold", b.out, 64'h55);
    b.wr_pulse = 1'b0;
    b.rn = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(b.out_valid), 64'd0);
    chk("t6_async_out", b.out, 64'd0);
    chk("t6_async_ovr", 64'(b.ovr_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    chk("t6_read_cleared", b.out, 64'd0);
    chk("t6_read_valid", 64'(b.out_valid), 64'd1);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);
    cyc(1'b0, 64'd0, 1'b1, 1'b1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
